// File: rtl/bsc_channel_injector.sv
// Channel-error injector: flips bits of a valid/ready hard-decision symbol stream using
// per-lane Galois LFSRs, in memoryless BSC or two-state Gilbert-Elliott burst mode.
module bsc_channel_injector #(
  parameter int unsigned N      = 2,
  parameter int unsigned PROB_W = 16,
  parameter logic [31:0] SEED   = 32'd54321
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      in_sym,
  input  logic              in_last,

  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      out_sym,
  output logic              out_last,
  output logic [N-1:0]      out_flip,

  input  logic              mode,
  input  logic [PROB_W-1:0] thr_good,
  input  logic [PROB_W-1:0] thr_bad,
  input  logic [PROB_W-1:0] thr_g2b,
  input  logic [PROB_W-1:0] thr_b2g,
  input  logic              reseed,
  input  logic              stats_clr,
  output logic              ge_bad,
  output logic [31:0]       sym_count,
  output logic [31:0]       flip_count
);

  localparam logic [31:0] LfsrMask = 32'h80200003;
  localparam logic [0:0]  StGood   = 1'b0;
  localparam logic [0:0]  StBad    = 1'b1;

  function automatic logic [31:0] fix_seed(input logic [31:0] s);
    return (s == 32'd0) ? 32'd1 : s;
  endfunction

  function automatic logic [31:0] lane_seed(input int unsigned idx);
    logic [31:0] k;
    k = 32'(idx + 1);
    return fix_seed(SEED ^ (k * 32'h9E3779B9));
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    return x[0] ? ((x >> 1) ^ LfsrMask) : (x >> 1);
  endfunction

  logic [31:0]       lane_q [N];
  logic [31:0]       st_lfsr_q;
  logic [0:0]        ge_state_q, ge_state_d;
  logic              out_valid_q, out_last_q;
  logic [N-1:0]      out_sym_q, out_flip_q;
  logic [31:0]       sym_cnt_q, sym_cnt_d;
  logic [31:0]       flip_cnt_q, flip_cnt_d;

  logic              accept;
  logic [PROB_W-1:0] thr;
  logic [PROB_W-1:0] st_rand;
  logic [N-1:0]      flip;
  logic [3:0]        flip_pop;
  logic [32:0]       flip_sum;

  assign in_ready = !reseed && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign thr      = (mode && (ge_state_q == StBad)) ? thr_bad : thr_good;
  assign st_rand  = st_lfsr_q[PROB_W-1:0];

  always_comb begin
    flip     = '0;
    flip_pop = '0;
    for (int unsigned i = 0; i < N; i++) begin
      flip[i]  = lane_q[i][PROB_W-1:0] < thr;
      flip_pop = flip_pop + {3'd0, flip[i]};
    end
  end

  // The transition decided here takes effect for the next accepted symbol.
  always_comb begin
    ge_state_d = ge_state_q;
    if (!mode) begin
      ge_state_d = StGood;
    end else begin
      unique case (ge_state_q)
        StGood:  if (st_rand < thr_g2b) ge_state_d = StBad;
        StBad:   if (st_rand < thr_b2g) ge_state_d = StGood;
        default: ge_state_d = StGood;
      endcase
    end
  end

  always_comb begin
    sym_cnt_d  = sym_cnt_q;
    flip_cnt_d = flip_cnt_q;
    flip_sum   = {1'b0, flip_cnt_q} + {29'd0, flip_pop};
    if (stats_clr) begin
      sym_cnt_d  = '0;
      flip_cnt_d = '0;
    end else if (accept) begin
      if (sym_cnt_q != 32'hFFFFFFFF) sym_cnt_d = sym_cnt_q + 32'd1;
      flip_cnt_d = flip_sum[32] ? 32'hFFFFFFFF : flip_sum[31:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N; i++) lane_q[i] <= lane_seed(i);
      st_lfsr_q   <= fix_seed(SEED ^ 32'h5A5A5A5A);
      ge_state_q  <= StGood;
      out_valid_q <= 1'b0;
      out_sym_q   <= '0;
      out_flip_q  <= '0;
      out_last_q  <= 1'b0;
      sym_cnt_q   <= '0;
      flip_cnt_q  <= '0;
    end else begin
      if (reseed) begin
        for (int unsigned i = 0; i < N; i++) lane_q[i] <= lane_seed(i);
        st_lfsr_q  <= fix_seed(SEED ^ 32'h5A5A5A5A);
        ge_state_q <= StGood;
      end else if (accept) begin
        for (int unsigned i = 0; i < N; i++) lane_q[i] <= lfsr_step(lane_q[i]);
        st_lfsr_q  <= lfsr_step(st_lfsr_q);
        ge_state_q <= ge_state_d;
      end

      // A held symbol may still drain while reseed blocks acceptance.
      if (accept) begin
        out_valid_q <= 1'b1;
        out_sym_q   <= in_sym ^ flip;
        out_flip_q  <= flip;
        out_last_q  <= in_last;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end

      sym_cnt_q  <= sym_cnt_d;
      flip_cnt_q <= flip_cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_sym    = out_sym_q;
  assign out_flip   = out_flip_q;
  assign out_last   = out_last_q;
  assign ge_bad     = (ge_state_q == StBad);
  assign sym_count  = sym_cnt_q;
  assign flip_count = flip_cnt_q;

endmodule

// File: tb/tb_bsc_channel_injector.sv
// Self-checking bench for bsc_channel_injector: behavioural LFSR/channel model, a table of
// seed-derived vectors, and randomized BSC, Gilbert-Elliott and backpressure runs.
module tb_bsc_channel_injector;
  localparam int unsigned N    = 2;
  localparam int unsigned PW   = 16;
  localparam logic [31:0] SEED = 32'd54321;
  localparam logic [31:0] MASK = 32'h80200003;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, in_valid, in_ready, in_last, out_valid, out_ready, out_last;
  logic [N-1:0]  in_sym, out_sym, out_flip;
  logic          mode, reseed, stats_clr, ge_bad;
  logic [PW-1:0] thr_good, thr_bad, thr_g2b, thr_b2g;
  logic [31:0]   sym_count, flip_count;

  bsc_channel_injector #(.N(N), .PROB_W(PW), .SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sym(in_sym), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sym(out_sym), .out_last(out_last),
    .out_flip(out_flip),
    .mode(mode), .thr_good(thr_good), .thr_bad(thr_bad), .thr_g2b(thr_g2b), .thr_b2g(thr_b2g),
    .reseed(reseed), .stats_clr(stats_clr), .ge_bad(ge_bad),
    .sym_count(sym_count), .flip_count(flip_count)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Behavioural channel model; index N of m_lfsr is the state LFSR.
  logic [31:0]  m_lfsr [N+1];
  logic         m_bad, m_ov, m_last;
  logic [N-1:0] m_sym, m_flip;
  logic [31:0]  m_sc, m_fc;
  logic [N-1:0] sb_q [$];
  logic         last_acc;

  function automatic logic [31:0] seed_of(input int i);
    logic [31:0] s;
    if (i < int'(N)) s = SEED ^ (32'(i + 1) * 32'h9E3779B9);
    else             s = SEED ^ 32'h5A5A5A5A;
    return (s == 32'd0) ? 32'd1 : s;
  endfunction

  function automatic logic [31:0] step(input logic [31:0] x);
    logic [31:0] y;
    y = x >> 1;
    if (x[0]) y = y ^ MASK;
    return y;
  endfunction

  task automatic model_seed();
    for (int i = 0; i <= int'(N); i++) m_lfsr[i] = seed_of(i);
    m_bad = 1'b0;
  endtask

  task automatic model_reset();
    model_seed();
    m_ov = 1'b0; m_sym = '0; m_flip = '0; m_last = 1'b0;
    m_sc = '0; m_fc = '0;
    sb_q.delete();
  endtask

  // One clock: check comb outputs mid-cycle, update the model, check registers after the edge.
  task automatic tick();
    logic          exp_ready, acc;
    logic [PW-1:0] thr, s;
    logic [N-1:0]  exp_in;
    longint        fsum;
    @(negedge clk);
    last_acc = 1'b0;
    if (!rst_n) begin
      model_reset();
    end else begin
      exp_ready = !reseed && (!m_ov || out_ready);
      chk("in_ready", 32'(in_ready), 32'(exp_ready));
      acc = in_valid && exp_ready;
      if (m_ov && out_ready) begin
        if (sb_q.size() == 0) fail("scoreboard_extra_symbol");
        else begin
          exp_in = sb_q.pop_front();
          chk("sb_data", 32'(out_sym ^ out_flip), 32'(exp_in));
        end
      end
      if (reseed) model_seed();
      if (acc) begin
        thr = (mode && m_bad) ? thr_bad : thr_good;
        for (int i = 0; i < int'(N); i++) m_flip[i] = (m_lfsr[i][PW-1:0] < thr);
        m_sym = in_sym ^ m_flip;
        m_last = in_last;
        m_ov = 1'b1;
        last_acc = 1'b1;
        sb_q.push_back(in_sym);
        if (m_sc != 32'hFFFFFFFF) m_sc = m_sc + 1;
        fsum = longint'(m_fc) + longint'($countones(m_flip));
        m_fc = (fsum > 64'hFFFFFFFF) ? 32'hFFFFFFFF : fsum[31:0];
        s = m_lfsr[N][PW-1:0];
        if (!mode)      m_bad = 1'b0;
        else if (m_bad) m_bad = !(s < thr_b2g);
        else            m_bad = (s < thr_g2b);
        for (int i = 0; i <= int'(N); i++) m_lfsr[i] = step(m_lfsr[i]);
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
      if (stats_clr) begin
        m_sc = '0;
        m_fc = '0;
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("out_sym", 32'(out_sym), 32'(m_sym));
    chk("out_flip", 32'(out_flip), 32'(m_flip));
    chk("out_last", 32'(out_last), 32'(m_last));
    chk("ge_bad", 32'(ge_bad), 32'(m_bad));
    chk("sym_count", sym_count, m_sc);
    chk("flip_count", flip_count, m_fc);
  endtask

  task automatic idle();
    in_valid = 1'b0; in_last = 1'b0; reseed = 1'b0; stats_clr = 1'b0;
  endtask

  task automatic do_reseed_clear();
    idle();
    reseed = 1'b1; stats_clr = 1'b1;
    tick();
    idle();
  endtask

  typedef struct {
    logic [PW-1:0] thr;
    logic [N-1:0]  sym;
    logic          last;
    logic [N-1:0]  e_sym;
    logic [N-1:0]  e_flip;
    logic          e_last;
  } vec_t;

  vec_t         vt [5];
  logic [N-1:0] rec_sym  [64];
  logic [N-1:0] rec_flip [64];

  initial begin
    // Lane draws after seeding: lane0 AD88,D6C4,EB62,F5B1,7ADB; lane1 2743,13A2,89D1,C4EB,E276.
    vt[0] = '{thr: 16'h0000, sym: 2'b10, last: 1'b0, e_sym: 2'b10, e_flip: 2'b00, e_last: 1'b0};
    vt[1] = '{thr: 16'hFFFF, sym: 2'b01, last: 1'b0, e_sym: 2'b10, e_flip: 2'b11, e_last: 1'b0};
    vt[2] = '{thr: 16'h8A00, sym: 2'b11, last: 1'b0, e_sym: 2'b01, e_flip: 2'b10, e_last: 1'b0};
    vt[3] = '{thr: 16'hF5B1, sym: 2'b00, last: 1'b0, e_sym: 2'b10, e_flip: 2'b10, e_last: 1'b0};
    vt[4] = '{thr: 16'h7ADC, sym: 2'b01, last: 1'b1, e_sym: 2'b00, e_flip: 2'b01, e_last: 1'b1};
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]    pat;
    logic          b, p1, p2;
    logic [N-1:0]  expf;
    logic          bad_before;
    int            sent, guard, bad_seen;

    rst_n = 1'b0; out_ready = 1'b1; in_sym = '0; mode = 1'b0;
    thr_good = '0; thr_bad = '0; thr_g2b = '0; thr_b2g = '0;
    idle();
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Pass-through of a K=3 (7,5) encoded pattern.
    pat = 8'b10110100; p1 = 1'b0; p2 = 1'b0;
    for (int k = 0; k < 64; k++) begin
      b = pat[7 - (k % 8)];
      in_sym = {b ^ p2, b ^ p1 ^ p2};
      p2 = p1; p1 = b;
      in_valid = 1'b1; in_last = (k == 63);
      tick();
      chk("pass_latency_sym", 32'(out_sym), 32'(in_sym));
      if (k == 63) chk("pass_last", 32'(out_last), 32'd1);
    end
    idle();
    tick();
    chk("pass_sym_count", sym_count, 32'd64);
    chk("pass_flip_count", flip_count, 32'd0);

    // Seed-derived table including the r == thr boundary.
    do_reseed_clear();
    for (int k = 0; k < 5; k++) begin
      thr_good = vt[k].thr; in_sym = vt[k].sym; in_last = vt[k].last; in_valid = 1'b1;
      tick();
      chk("tbl_sym", 32'(out_sym), 32'(vt[k].e_sym));
      chk("tbl_flip", 32'(out_flip), 32'(vt[k].e_flip));
      chk("tbl_last", 32'(out_last), 32'(vt[k].e_last));
    end
    idle();
    tick();
    chk("tbl_flip_count", flip_count, 32'd5);
    chk("tbl_sym_count", sym_count, 32'd5);

    // BSC at ~2%, then replay after reseed.
    thr_good = 16'd1311;
    do_reseed_clear();
    for (int k = 0; k < 64; k++) begin
      rec_sym[k] = N'($urandom);
      in_sym = rec_sym[k]; in_valid = 1'b1;
      tick();
      rec_flip[k] = m_flip;
    end
    do_reseed_clear();
    for (int k = 0; k < 64; k++) begin
      in_sym = rec_sym[k]; in_valid = 1'b1;
      tick();
      chk("replay_flip", 32'(out_flip), 32'(rec_flip[k]));
    end

    // All-ones threshold flips unless the draw is all-ones.
    thr_good = 16'hFFFF;
    for (int k = 0; k < 64; k++) begin
      for (int i = 0; i < int'(N); i++) expf[i] = (m_lfsr[i][PW-1:0] != 16'hFFFF);
      in_sym = N'($urandom); in_valid = 1'b1;
      tick();
      chk("sat_flip", 32'(out_flip), 32'(expf));
    end

    // Gilbert-Elliott bursts.
    idle();
    mode = 1'b1; thr_good = 16'h0000; thr_bad = 16'hFFFF; thr_g2b = 16'h2000; thr_b2g = 16'h4000;
    do_reseed_clear();
    bad_seen = 0;
    for (int k = 0; k < 300; k++) begin
      bad_before = m_bad;
      for (int i = 0; i < int'(N); i++)
        expf[i] = bad_before && (m_lfsr[i][PW-1:0] != 16'hFFFF);
      in_sym = N'($urandom); in_valid = ($urandom_range(0, 3) != 0);
      tick();
      if (last_acc) chk("ge_flip", 32'(out_flip), 32'(expf));
      if (ge_bad) bad_seen++;
    end
    chk("ge_bad_seen", 32'(bad_seen != 0), 32'd1);

    // Random backpressure.
    idle();
    mode = 1'b0; thr_good = 16'd1311;
    stats_clr = 1'b1;
    tick();
    idle();
    sent = 0;
    for (int cyc = 0; cyc < 5000 && sent < 200; cyc++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_sym = N'($urandom);
      in_last = (sent == 199);
      out_ready = $urandom_range(0, 1);
      tick();
      if (last_acc) sent++;
    end
    if (sent < 200) fail("bp_send_timeout");
    idle();
    out_ready = 1'b1;
    guard = 0;
    while (m_ov && guard < 50) begin
      tick();
      guard++;
    end
    if (m_ov) fail("bp_drain_timeout");
    chk("bp_sym_count", sym_count, 32'd200);
    chk("bp_sb_empty", 32'(sb_q.size()), 32'd0);

    // Reseed while a stalled symbol is held; it must survive and then drain.
    out_ready = 1'b0; in_valid = 1'b1; in_sym = 2'b11;
    tick();
    in_valid = 1'b1; reseed = 1'b1;
    tick();
    chk("reseed_in_ready", 32'(in_ready), 32'd0);
    idle();
    out_ready = 1'b1;
    tick();

    // stats_clr alongside an acceptance.
    in_valid = 1'b1; stats_clr = 1'b1;
    tick();
    chk("clr_sym_count", sym_count, 32'd0);
    chk("clr_flip_count", flip_count, 32'd0);
    idle();

    // Mid-frame reset, then seeds must be in force.
    thr_good = 16'hFFFF;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_sym = N'($urandom);
      tick();
    end
    rst_n = 1'b0;
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sym", 32'(out_sym), 32'd0);
    chk("rst_sym_count", sym_count, 32'd0);
    rst_n = 1'b1;
    in_valid = 1'b1; in_sym = 2'b00; thr_good = 16'hFFFF;
    tick();
    chk("rst_seed_flip0", 32'(out_flip), 32'd3);
    thr_good = 16'h2000;
    tick();
    chk("rst_seed_flip1", 32'(out_flip), 32'd2);
    idle();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
